// File: rtl/button_press_decoder.sv
// button_press_decoder
// Classifies debounced button events into short presses, long presses and
// (optionally) auto-repeat ticks while the button stays held.
// The optional feature is controlled by the macro BUTTON_PRESS_DECODER_REPEAT_EN:
//   defined   -> repeat counter built, o_repeat pulses every REPEAT_CYCLES in LONG
//   undefined -> no repeat counter, o_repeat tied low, LONG waits only for release
// All outputs are registered; every output pulse lasts exactly one cycle.
// The repeat pulse is named o_repeat because "repeat" is a reserved word.
module button_press_decoder #(
  parameter int HOLD_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_down,
  input  logic i_up,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  // Terminal counts: cnt starts at 0 on the edge that samples down, so
  // cnt == HOLD_CYCLES-1 is seen exactly HOLD_CYCLES edges after the press.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short_press;
  logic             r_long_press;
  logic             r_held;

`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_rcnt;
  logic             r_repeat;
`endif

  // Press classification FSM with registered one-cycle pulse outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
      r_held        <= 1'b0;
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
      r_rcnt        <= '0;
      r_repeat      <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low each cycle and are only set by the branch
      // that fires, which guarantees single-cycle width without extra logic.
      r_short_press <= 1'b0;
      r_long_press  <= 1'b0;
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
      r_repeat      <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          // A lone up, or down and up together, carries no press information.
          if (i_down && !i_up) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end
        end

        ST_PRESSED: begin
          // Release wins over a coincident hold threshold.
          if (i_up) begin
            r_state       <= ST_IDLE;
            r_short_press <= 1'b1;
          end else if (r_cnt == HOLD_LAST) begin
            r_state      <= ST_LONG;
            r_long_press <= 1'b1;
            r_held       <= 1'b1;
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
            r_rcnt       <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_LONG: begin
          // Release ends the hold silently and also beats a repeat terminal count.
          if (i_up) begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
          end
`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
          else if (r_rcnt == REPEAT_LAST) begin
            r_repeat <= 1'b1;
            r_rcnt   <= '0;
          end else begin
            r_rcnt <= r_rcnt + CNT_ONE;
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign o_short_press = r_short_press;
  assign o_long_press  = r_long_press;
  assign o_held        = r_held;

`ifdef BUTTON_PRESS_DECODER_REPEAT_EN
  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: doc/button_press_decoder.md
# button_press_decoder

Consumes the single-cycle `down`/`up` event pulses from a button debouncer and classifies each press as short, long, or held-with-auto-repeat. It sits between the debouncers and the clock-shield time-setting logic, which steps digits on `short_press`, enters set mode on `long_press`, and fast-steps on `repeat`. Everything runs in the `clk` domain, and all outputs are registered.

## Interface
- `HOLD_CYCLES`, default 25_000_000: press duration in cycles that qualifies as long (0.5 s at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, default 5_000_000: auto-repeat period in cycles while held; must be ≥ 2.
- `CNT_W`, default 25: counter width; requires 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES).
- `clk  input  1`: system clock; all logic on its rising edge.
- `rst  input  1`: reset, asynchronous and active-high.
- `down  input  1`: one-cycle pulse when the debounced button is pressed.
- `up  input  1`: one-cycle pulse when the debounced button is released.
- `short_press  output  1`: one-cycle pulse on a release before the long threshold.
- `long_press  output  1`: one-cycle pulse when the hold reaches `HOLD_CYCLES`.
- `repeat  output  1`: one-cycle pulse every `REPEAT_CYCLES` while held past the long threshold.
- `held  output  1`: level, high while in LONG.

## Operation
States and their transitions:
- **IDLE**
  - `down & ~up`: go to PRESSED, `cnt <= 0`.
  - `up` alone is ignored.
  - `down & up` together are ignored.
- **PRESSED**
  - Each cycle, `cnt <= cnt + 1`.
  - `up`: go to IDLE and pulse `short_press`.
  - `cnt == HOLD_CYCLES-1` (and no `up`): go to LONG, pulse `long_press`, `rcnt <= 0`.
  - Simultaneous `up` and threshold: `up` wins. The response is `short_press` only, with no `long_press`.
  - `down` is ignored.
- **LONG**
  - `held = 1`.
  - Each cycle, `rcnt <= rcnt + 1`.
  - `rcnt == REPEAT_CYCLES-1`: pulse `repeat`, `rcnt <= 0`.
  - `up`: go to IDLE with no pulse of any kind. `up` also wins over a coincident repeat terminal count.
  - `down` is ignored.
- Output pulses:
  - Never more than one output pulse is asserted in any cycle.
  - Each pulse lasts exactly one cycle.
- Reset (asynchronous, including mid-press):
  - State returns to IDLE.
  - `cnt`, `rcnt` and all outputs go to 0.
  - No pulse is generated. A later `up` is ignored, and a fresh `down` is required.
- Arithmetic:
  - Counters are unsigned `CNT_W` bits.
  - Counters never wrap, because the terminal compare always leaves the state or clears the counter first.

## Timing
Let edge k be the clock edge at which `down` is sampled high in IDLE.
- `long_press` is high for the single cycle following edge k+HOLD_CYCLES, provided no `up` was sampled at edges k+1…k+HOLD_CYCLES.
- `up` sampled at edge k+j, with 1 ≤ j ≤ HOLD_CYCLES: `short_press` is high for the cycle following edge k+j.
- `held`:
  - Rises together with `long_press`.
  - Falls in the cycle after the edge at which `up` is sampled.
- `repeat` (when compiled in): high for the cycle following edge k+HOLD_CYCLES+m·REPEAT_CYCLES, for m = 1, 2, …, while no `up` has been sampled at or before that edge.
- Latency: one cycle from the sampled input event to the registered output.
- Back-to-back presses: a `down` sampled in the first cycle after returning to IDLE is accepted.
- Reset values: `short_press=0`, `long_press=0`, `repeat=0`, `held=0`.

## Configuration
- `BUTTON_PRESS_DECODER_REPEAT_EN` defined:
  - The `rcnt` counter and `repeat` pulses are built as described above.
- `BUTTON_PRESS_DECODER_REPEAT_EN` undefined:
  - `rcnt` is not instantiated.
  - `repeat` is tied to 0.
  - LONG waits only for `up`.
  - `short_press`, `long_press` and `held` behave identically in both builds.

## Test plan
All scenarios use HOLD_CYCLES=10, REPEAT_CYCLES=4, CNT_W=4, with the macro defined unless stated otherwise.
1. **Short press.** `down` at edge 0, `up` at edge 5 → `short_press` high for one cycle after edge 5; `long_press`, `repeat` and `held` stay 0.
2. **Threshold tie.** `down` at edge 0, `up` at edge 10 → `short_press` only; `long_press` never asserts.
3. **Long press with repeat.** `down` at edge 0, `up` at edge 20:
   - `long_press` after edge 10.
   - `repeat` after edges 14 and 18.
   - `held` high from after edge 10 through edge 20.
   - No pulse at edge 20.
4. **Repeat tie.** `down` at edge 0, `up` at edge 14 → `long_press` only, with no `repeat`. With the macro undefined, the 20-edge hold of scenario 3 gives `long_press` and `held` only, and `repeat` stays 0.
5. **Reset mid-press.**
   - `down` at edge 0, `rst` pulsed between edges 5 and 6, `up` at edge 8 → all outputs 0 throughout, and reset clears outputs without waiting for a clock.
   - Then `down` at edge 12, `up` at edge 14 → `short_press` after edge 14.
6. **Spurious events.**
   - `up` in IDLE, `down` while PRESSED, `down` and `up` in the same cycle while IDLE → no state change and no pulses.
   - A press whose `down` is sampled one cycle after a `short_press` is accepted normally.
